bcd_accum_serial: RTL and testbench

- Parametrised N-digit BCD accumulator that adds or subtracts a BCD operand into a held total.
- Processes one digit per clock, LSD first, and wraps the operation in a start/busy/done handshake.
- Generalises the fixed 4-digit combinational BCD add/sub path to DIGITS width with registered state and overflow/borrow/error flags.
- Used by game and scoreboard logic, such as fuel/score counters, that feed seven-segment decoders.

---
 rtl/bcd_accum_serial_pkg.sv | 20 ++
 rtl/bcd_accum_serial_if.sv | 26 ++
 rtl/bcd_digit_addsub.sv | 30 +++
 rtl/bcd_accum_serial.sv | 155 +++++++++++++++
 tb/tb_bcd_accum_serial.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/bcd_accum_serial_pkg.sv
// Shared types and helpers for the serial BCD accumulator (package bcd_pkg).
package bcd_pkg;

    localparam int         DIGIT_W = 4;
    localparam logic [3:0] BCD_MAX = 4'd9;

    typedef logic [DIGIT_W-1:0] bcd_digit_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // A nibble is a legal BCD digit only in the range 0..9.
    function automatic logic bcd_digit_valid(input bcd_digit_t d);
        return (d <= BCD_MAX);
    endfunction

endpackage

// File: rtl/bcd_accum_serial_if.sv
// Request/result bundle between a controller and the serial BCD accumulator.
interface bcd_accum_serial_if #(
    parameter int DIGITS = 4
);
    logic                  start;
    logic                  op;
    logic [4*DIGITS-1:0]   operand;
    logic                  load;
    logic [4*DIGITS-1:0]   load_val;
    logic [4*DIGITS-1:0]   acc;
    logic                  busy;
    logic                  done;
    logic                  carry;
    logic                  borrow;
    logic                  err;

    modport master (
        output start, op, operand, load, load_val,
        input  acc, busy, done, carry, borrow, err
    );

    modport slave (
        input  start, op, operand, load, load_val,
        output acc, busy, done, carry, borrow, err
    );
endinterface

// File: rtl/bcd_digit_addsub.sv
// Single BCD digit adder; comp selects the 9's complement of b so the same
// cell performs subtraction when the carry chain is seeded with 1.
module bcd_digit_addsub
    import bcd_pkg::*;
(
    input  bcd_digit_t a,
    input  bcd_digit_t b,
    input  logic       ci,
    input  logic       comp,
    output bcd_digit_t s,
    output logic       co
);

    bcd_digit_t b_eff;
    logic [4:0] sum;

    // Binary sum followed by the +6 decimal correction when it exceeds 9.
    always_comb begin
        b_eff = comp ? (BCD_MAX - b) : b;
        sum   = {1'b0, a} + {1'b0, b_eff} + {4'd0, ci};
        if (sum > 5'd9) begin
            s  = sum[3:0] + 4'd6;
            co = 1'b1;
        end else begin
            s  = sum[3:0];
            co = 1'b0;
        end
    end

endmodule

// File: rtl/bcd_accum_serial.sv
// Serial N-digit BCD accumulator: one digit per clock, LSD first.
// Build option: define BCD_ACCUM_SAT_EN to saturate acc on carry/borrow
// instead of wrapping; flags are reported identically either way.
module bcd_accum_serial
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
)(
    input  logic               clk,
    input  logic               reset,
    bcd_accum_serial_if.slave  bus
);

    localparam int W     = DIGIT_W * DIGITS;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    state_t           state, next_state;
    logic [W-1:0]     acc_q;
    logic [W-1:0]     opnd_sh;
    logic [W-1:0]     res_sh;
    logic [W-1:0]     commit_val;
    logic             op_sh;
    logic             c_q;
    logic [IDX_W-1:0] idx;
    logic             carry_q, borrow_q, err_q;
    logic             operand_ok, load_ok, last_digit;
    bcd_digit_t       dig_a, dig_b, dig_s;
    logic             dig_co;

    // Reject any word containing a nibble above 9.
    always_comb begin
        operand_ok = 1'b1;
        load_ok    = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (!bcd_digit_valid(bus.operand[i*DIGIT_W +: DIGIT_W]))
                operand_ok = 1'b0;
            if (!bcd_digit_valid(bus.load_val[i*DIGIT_W +: DIGIT_W]))
                load_ok = 1'b0;
        end
    end

    assign last_digit = (idx == IDX_W'(DIGITS - 1));
    assign dig_a      = acc_q[{idx, 2'b00} +: DIGIT_W];
    assign dig_b      = opnd_sh[{idx, 2'b00} +: DIGIT_W];

    bcd_digit_addsub u_digit (
        .a    (dig_a),
        .b    (dig_b),
        .ci   (c_q),
        .comp (op_sh),
        .s    (dig_s),
        .co   (dig_co)
    );

    // Shadow result with the digit being computed this cycle merged in.
    always_comb begin
        commit_val = res_sh;
        commit_val[{idx, 2'b00} +: DIGIT_W] = dig_s;
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // Next-state: load has priority over start; bad operands skip RUN.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (!bus.load && bus.start)
                    next_state = operand_ok ? RUN : DONE;
            end
            RUN:     if (last_digit) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Datapath: accept/load in IDLE, digit walk in RUN, commit on last digit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q    <= '0;
            opnd_sh  <= '0;
            res_sh   <= '0;
            op_sh    <= 1'b0;
            c_q      <= 1'b0;
            idx      <= '0;
            carry_q  <= 1'b0;
            borrow_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.load) begin
                        carry_q  <= 1'b0;
                        borrow_q <= 1'b0;
                        if (load_ok) begin
                            acc_q <= bus.load_val;
                            err_q <= 1'b0;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end else if (bus.start) begin
                        opnd_sh <= bus.operand;
                        op_sh   <= bus.op;
                        c_q     <= bus.op;
                        idx     <= '0;
                        res_sh  <= '0;
                        if (!operand_ok) begin
                            err_q    <= 1'b1;
                            carry_q  <= 1'b0;
                            borrow_q <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    res_sh[{idx, 2'b00} +: DIGIT_W] <= dig_s;
                    c_q <= dig_co;
                    idx <= idx + 1'b1;
                    if (last_digit) begin
                        err_q <= 1'b0;
                        if (op_sh) begin
                            carry_q  <= 1'b0;
                            borrow_q <= ~dig_co;
                        end else begin
                            carry_q  <= dig_co;
                            borrow_q <= 1'b0;
                        end
`ifdef BCD_ACCUM_SAT_EN
                        if (!op_sh && dig_co)
                            acc_q <= {DIGITS{BCD_MAX}};
                        else if (op_sh && !dig_co)
                            acc_q <= '0;
                        else
                            acc_q <= commit_val;
`else
                        acc_q <= commit_val;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.acc    = acc_q;
    assign bus.busy   = (state != IDLE);
    assign bus.done   = (state == DONE);
    assign bus.carry  = carry_q;
    assign bus.borrow = borrow_q;
    assign bus.err    = err_q;

endmodule

// File: tb/tb_bcd_accum_serial.sv
// Directed + random bench for bcd_accum_serial with a decimal reference model
// and an expected-result queue popped on each done pulse.
module tb_bcd_accum_serial;

    localparam int DIGITS = 4;
    localparam int W      = 4 * DIGITS;
    localparam int POW    = 10000;

    typedef struct {
        logic [W-1:0] acc;
        logic         carry;
        logic         borrow;
        logic         err;
        int           lat;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    bcd_accum_serial_if #(.DIGITS(DIGITS)) bus();
    bcd_accum_serial #(.DIGITS(DIGITS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   m_acc;
    logic m_carry, m_borrow, m_err;

    function automatic int bcd2int(input logic [W-1:0] v);
        int r = 0;
        for (int i = DIGITS - 1; i >= 0; i--) r = r * 10 + int'(v[i*4 +: 4]);
        return r;
    endfunction

    function automatic logic [W-1:0] int2bcd(input int x);
        logic [W-1:0] r = '0;
        int t = x;
        for (int i = 0; i < DIGITS; i++) begin
            r[i*4 +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic bit word_ok(input logic [W-1:0] v);
        bit ok = 1'b1;
        for (int i = 0; i < DIGITS; i++) if (v[i*4 +: 4] > 4'd9) ok = 1'b0;
        return ok;
    endfunction

    function automatic logic [W-1:0] rand_bcd();
        logic [W-1:0] r;
        for (int i = 0; i < DIGITS; i++) r[i*4 +: 4] = 4'($urandom_range(0, 9));
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_flags(input string tag);
        check({tag, "_acc"},    32'(bus.acc),    32'(int2bcd(m_acc)));
        check({tag, "_carry"},  32'(bus.carry),  32'(m_carry));
        check({tag, "_borrow"}, 32'(bus.borrow), 32'(m_borrow));
        check({tag, "_err"},    32'(bus.err),    32'(m_err));
    endtask

    task automatic do_load(input logic [W-1:0] v, input bit with_start);
        bus.load     = 1'b1;
        bus.load_val = v;
        bus.start    = with_start;
        bus.op       = 1'b0;
        bus.operand  = 16'h1111;
        @(posedge clk);
        #1;
        bus.load  = 1'b0;
        bus.start = 1'b0;
        m_carry  = 1'b0;
        m_borrow = 1'b0;
        if (word_ok(v)) begin
            m_acc = bcd2int(v);
            m_err = 1'b0;
        end else begin
            m_err = 1'b1;
        end
        check_flags("load");
        check("load_done", 32'(bus.done), 32'd0);
        check("load_busy", 32'(bus.busy), 32'd0);
    endtask

    task automatic model_op(input bit o, input logic [W-1:0] v);
        exp_t e;
        int   x;
        if (!word_ok(v)) begin
            m_err = 1'b1; m_carry = 1'b0; m_borrow = 1'b0;
            e.lat = 0;
        end else begin
            m_err = 1'b0;
            e.lat = DIGITS;
            if (!o) begin
                x = m_acc + bcd2int(v);
                m_carry = (x >= POW); m_borrow = 1'b0;
                m_acc = x % POW;
`ifdef BCD_ACCUM_SAT_EN
                if (m_carry) m_acc = POW - 1;
`endif
            end else begin
                x = m_acc - bcd2int(v);
                m_borrow = (x < 0); m_carry = 1'b0;
                m_acc = m_borrow ? x + POW : x;
`ifdef BCD_ACCUM_SAT_EN
                if (m_borrow) m_acc = 0;
`endif
            end
        end
        e.acc = int2bcd(m_acc); e.carry = m_carry; e.borrow = m_borrow; e.err = m_err;
        exp_q.push_back(e);
    endtask

    task automatic run_op(input bit o, input logic [W-1:0] v, input bit inject);
        logic [W-1:0] pre;
        exp_t e;
        int   n;
        bit   got;
        pre = bus.acc;
        model_op(o, v);
        bus.start = 1'b1; bus.op = o; bus.operand = v;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        n = 0;
        got = bus.done;
        while (!got && n < 4 * DIGITS) begin
            if (inject && n == 1) begin
                bus.start = 1'b1; bus.op = ~o; bus.operand = 16'h1111;
                bus.load = 1'b1; bus.load_val = 16'h7777;
            end
            if (inject && n == 3) begin
                bus.start = 1'b0; bus.load = 1'b0;
            end
            check("run_acc_stable", 32'(bus.acc), 32'(pre));
            @(posedge clk);
            #1;
            n++;
            got = bus.done;
        end
        bus.start = 1'b0; bus.load = 1'b0;
        e = exp_q.pop_front();
        if (!got) begin
            n_vec++;
            n_err++;
            $error("FAIL done_timeout observed=no_done expected=done_after_%0d", e.lat);
        end else begin
            check("latency",    32'(n),          32'(e.lat));
            check("done_acc",   32'(bus.acc),    32'(e.acc));
            check("done_carry", 32'(bus.carry),  32'(e.carry));
            check("done_borrow",32'(bus.borrow), 32'(e.borrow));
            check("done_err",   32'(bus.err),    32'(e.err));
            check("done_busy",  32'(bus.busy),   32'd1);
        end
        @(posedge clk);
        #1;
        check("post_done",  32'(bus.done), 32'd0);
        check("post_busy",  32'(bus.busy), 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        bus.start = 1'b0; bus.op = 1'b0; bus.operand = '0;
        bus.load = 1'b0; bus.load_val = '0;
        m_acc = 0; m_carry = 1'b0; m_borrow = 1'b0; m_err = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_flags("reset");
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_done", 32'(bus.done), 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        do_load(16'h1234, 1'b0);
        run_op(1'b0, 16'h0999, 1'b0);

        do_load(16'h9999, 1'b0);
        run_op(1'b0, 16'h0001, 1'b0);

        do_load(16'h0005, 1'b0);
        run_op(1'b1, 16'h0007, 1'b0);

        do_load(16'h0500, 1'b0);
        run_op(1'b1, 16'h0123, 1'b0);
        do_load(16'h00F1, 1'b0);

        run_op(1'b0, 16'h12A4, 1'b0);

        // load and start together: load wins, no operation runs
        do_load(16'h3333, 1'b1);
        @(posedge clk);
        #1;
        check("ld_start_busy", 32'(bus.busy), 32'd0);

        // start/load while busy are ignored and not queued
        run_op(1'b0, 16'h0456, 1'b1);
        @(posedge clk);
        #1;
        check("no_queued_busy", 32'(bus.busy), 32'd0);
        check_flags("after_inject");

        for (int k = 0; k < 8; k++) run_op(1'($urandom_range(0, 1)), rand_bcd(), 1'b0);

        // reset in the middle of RUN aborts with no commit
        do_load(16'h4321, 1'b0);
        bus.start = 1'b1; bus.op = 1'b0; bus.operand = 16'h1111;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        m_acc = 0; m_carry = 1'b0; m_borrow = 1'b0; m_err = 1'b0;
        check_flags("mid_reset");
        check("mid_reset_busy", 32'(bus.busy), 32'd0);
        check("mid_reset_done", 32'(bus.done), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        run_op(1'b0, 16'h0042, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
